// File: rtl/br_pe_traffic_agent_if.sv
// BrLite PE traffic agent: shared types and the command/NoC bus.
// slave = agent side, master = PE/NoC side.
package br_pkg;
  typedef enum logic [1:0] {
    BR_SVC_ALL = 2'd0,
    BR_SVC_TGT = 2'd1,
    BR_SVC_CLR = 2'd2,
    BR_SVC_MON = 2'd3
  } br_svc_t;

  typedef logic [7:0]  br_tgt_t;
  typedef logic [31:0] br_pl_t;

  typedef struct packed {
    logic [7:0] seq_source;
    br_tgt_t    seq_target;
    br_pl_t     payload;
    br_svc_t    service;
    logic [4:0] id;
  } br_data_t;
endpackage

// Ports: cmd_* injection queue handshake,
// noc_*_o/noc_*_i injection and delivery handshakes.
interface br_pe_traffic_agent_if;
  import br_pkg::*;

  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [63:0] cmd_time_i;
  br_tgt_t     cmd_target_i;
  br_pl_t      cmd_payload_i;
  br_svc_t     cmd_service_i;

  br_data_t    noc_flit_o;
  logic        noc_req_o;
  logic        noc_ack_i;
  logic        noc_busy_i;

  br_data_t    noc_flit_i;
  logic        noc_req_i;
  logic        noc_ack_o;

  modport slave (
    input  cmd_valid_i, cmd_time_i,
    input  cmd_target_i, cmd_payload_i,
    input  cmd_service_i,
    output cmd_ready_o,
    output noc_flit_o, noc_req_o,
    input  noc_ack_i, noc_busy_i,
    input  noc_flit_i, noc_req_i,
    output noc_ack_o
  );

  modport master (
    output cmd_valid_i, cmd_time_i,
    output cmd_target_i, cmd_payload_i,
    output cmd_service_i,
    input  cmd_ready_o,
    input  noc_flit_o, noc_req_o,
    output noc_ack_i, noc_busy_i,
    output noc_flit_i, noc_req_i,
    input  noc_ack_o
  );
endinterface

// File: rtl/br_pe_traffic_agent.sv
// BrLite per-PE traffic agent: timed injection queue, id gen,
// delayed delivery ack, saturating service counters.
// Ports: clk_i, rst_ni (sync, low), tick_cnt_i, bus (slave),
// rx_valid_o/rx_flit_o last delivery, rx_*_cnt_o, tx_cnt_o, idle_o.
module br_pe_traffic_agent
  import br_pkg::*;
#(
  parameter int PE_ID      = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int RX_ACK_DLY = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [63:0]      tick_cnt_i,
  br_pe_traffic_agent_if.slave bus,
  output logic             rx_valid_o,
  output br_data_t         rx_flit_o,
  output logic [CNT_W-1:0] rx_all_cnt_o,
  output logic [CNT_W-1:0] rx_tgt_cnt_o,
  output logic [CNT_W-1:0] tx_cnt_o,
  output logic             idle_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [63:0] t;
    br_tgt_t     tgt;
    br_pl_t      pl;
    br_svc_t     svc;
  } cmd_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_ARM, TX_REQ, TX_REL
  } tx_st_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_DLY, RX_ACK
  } rx_st_t;

  cmd_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_nxt;
  logic          ready_q;
  cmd_t          head;
  logic          push, pop;

  tx_st_t        tx_st, tx_nxt;
  logic          fire, tx_done;
  logic          req_q;
  br_data_t      flit_q;
  logic [4:0]    id_q;

  rx_st_t        rx_st, rx_nxt;
  logic          cap, ack_set, ack_clr;
  logic [3:0]    dly_cnt;
  logic          ack_q;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  assign head = mem[rptr];
  assign push = bus.cmd_valid_i && ready_q;
  assign pop  = fire;

  assign bus.cmd_ready_o = ready_q;
  assign bus.noc_req_o   = req_q;
  assign bus.noc_flit_o  = flit_q;
  assign bus.noc_ack_o   = ack_q;

  assign idle_o = (count == '0) &&
                  (tx_st == TX_IDLE) &&
                  (rx_st == RX_IDLE);

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (!push && pop)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr].t   <= bus.cmd_time_i;
      mem[wptr].tgt <= bus.cmd_target_i;
      mem[wptr].pl  <= bus.cmd_payload_i;
      mem[wptr].svc <= bus.cmd_service_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count   <= count_nxt;
      ready_q <= (count_nxt != FULL);
    end
  end

  always_comb begin
    tx_nxt  = tx_st;
    fire    = 1'b0;
    tx_done = 1'b0;
    unique case (tx_st)
      TX_IDLE:
        if (count != '0) tx_nxt = TX_ARM;
      TX_ARM:
        if (tick_cnt_i >= head.t &&
            !bus.noc_busy_i) begin
          fire   = 1'b1;
          tx_nxt = TX_REQ;
        end
      TX_REQ:
        if (bus.noc_ack_i) begin
          tx_done = 1'b1;
          tx_nxt  = TX_REL;
        end
      TX_REL:
        if (!bus.noc_ack_i) tx_nxt = TX_IDLE;
      default: tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tx_st    <= TX_IDLE;
      req_q    <= 1'b0;
      flit_q   <= '0;
      id_q     <= '0;
      tx_cnt_o <= '0;
    end else begin
      tx_st <= tx_nxt;
      if (fire) begin
        flit_q.seq_source <= 8'(PE_ID);
        flit_q.seq_target <= head.tgt;
        flit_q.payload    <= head.pl;
        flit_q.service    <= head.svc;
        flit_q.id         <= id_q;
        req_q             <= 1'b1;
        id_q              <= id_q + 5'd1;
      end
      if (tx_done) begin
        req_q    <= 1'b0;
        tx_cnt_o <= sat_inc(tx_cnt_o);
      end
    end
  end

  // dly_cnt counts DLY cycles already spent; ack is raised
  // once RX_ACK_DLY of them have elapsed (at least one).
  always_comb begin
    rx_nxt  = rx_st;
    cap     = 1'b0;
    ack_set = 1'b0;
    ack_clr = 1'b0;
    unique case (rx_st)
      RX_IDLE:
        if (bus.noc_req_i) begin
          cap    = 1'b1;
          rx_nxt = RX_DLY;
        end
      RX_DLY:
        if ({1'b0, dly_cnt} + 5'd1 >=
            5'(RX_ACK_DLY)) begin
          ack_set = 1'b1;
          rx_nxt  = RX_ACK;
        end
      RX_ACK:
        if (!bus.noc_req_i) begin
          ack_clr = 1'b1;
          rx_nxt  = RX_IDLE;
        end
      default: rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_st        <= RX_IDLE;
      dly_cnt      <= '0;
      ack_q        <= 1'b0;
      rx_valid_o   <= 1'b0;
      rx_flit_o    <= '0;
      rx_all_cnt_o <= '0;
      rx_tgt_cnt_o <= '0;
    end else begin
      rx_st      <= rx_nxt;
      rx_valid_o <= cap;
      if (cap) begin
        dly_cnt   <= '0;
        rx_flit_o <= bus.noc_flit_i;
        if (bus.noc_flit_i.service == BR_SVC_ALL)
          rx_all_cnt_o <= sat_inc(rx_all_cnt_o);
        else
          rx_tgt_cnt_o <= sat_inc(rx_tgt_cnt_o);
      end else if (rx_st == RX_DLY && !ack_set) begin
        dly_cnt <= dly_cnt + 4'd1;
      end
      if (ack_set) ack_q <= 1'b1;
      if (ack_clr) ack_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_br_pe_traffic_agent.sv
// Scoreboard bench for br_pe_traffic_agent.
// dut_a: PE 5, ack dly 3; dut_b: PE 2, ack dly 0, CNT_W 4.
module tb_br_pe_traffic_agent;
  import br_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] tick = '0;
  always @(posedge clk) tick <= tick + 64'd1;

  br_pe_traffic_agent_if ifa ();
  br_pe_traffic_agent_if ifb ();

  logic        rxv_a, rxv_b, idle_a, idle_b;
  br_data_t    rxf_a, rxf_b;
  logic [15:0] rxall_a, rxtgt_a, tx_a;
  logic [3:0]  rxall_b, rxtgt_b, tx_b;

  br_pe_traffic_agent #(
    .PE_ID(5), .FIFO_DEPTH(4),
    .RX_ACK_DLY(3), .CNT_W(16)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .tick_cnt_i(tick), .bus(ifa),
    .rx_valid_o(rxv_a), .rx_flit_o(rxf_a),
    .rx_all_cnt_o(rxall_a),
    .rx_tgt_cnt_o(rxtgt_a),
    .tx_cnt_o(tx_a), .idle_o(idle_a)
  );

  br_pe_traffic_agent #(
    .PE_ID(2), .FIFO_DEPTH(4),
    .RX_ACK_DLY(0), .CNT_W(4)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .tick_cnt_i(tick), .bus(ifb),
    .rx_valid_o(rxv_b), .rx_flit_o(rxf_b),
    .rx_all_cnt_o(rxall_b),
    .rx_tgt_cnt_o(rxtgt_b),
    .tx_cnt_o(tx_b), .idle_o(idle_b)
  );

  int checks   = 0;
  int failures = 0;
  int exp_id   = 0;
  bit hold     = 1'b0;

  typedef struct {
    br_data_t    flit;
    logic [63:0] at;
    bit          exact;
  } tx_exp_t;

  tx_exp_t  txq[$];
  br_data_t rxq_a[$];
  br_data_t rxq_b[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               nm, act, exp);
    end
  endtask

  // NoC side of injection: ack two cycles after req.
  initial begin
    ifa.noc_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!hold && ifa.noc_req_o && !ifa.noc_ack_i) begin
        repeat (2) @(negedge clk);
        ifa.noc_ack_i = 1'b1;
      end else if (!ifa.noc_req_o && ifa.noc_ack_i) begin
        ifa.noc_ack_i = 1'b0;
      end
    end
  end

  logic     prev_req = 1'b0;
  br_data_t last_flit = '0;

  always @(negedge clk) begin : tx_mon
    tx_exp_t e;
    if (rst_n && ifa.noc_req_o && !prev_req) begin
      if (txq.size() == 0) begin
        chk("tx_unexpected", 64'(txq.size()), 64'd1);
      end else begin
        e = txq.pop_front();
        chk("tx_flit", 64'(ifa.noc_flit_o), 64'(e.flit));
        if (e.exact)
          chk("tx_tick", tick - 64'd1, e.at);
        else
          chk("tx_tick_ge",
              64'(tick - 64'd1 >= e.at), 64'd1);
      end
    end
    if (rst_n && ifa.noc_req_o && prev_req)
      chk("tx_stable", 64'(ifa.noc_flit_o),
          64'(last_flit));
    prev_req  <= ifa.noc_req_o;
    last_flit <= ifa.noc_flit_o;
  end

  logic prev_rxv_a = 1'b0;
  logic prev_rxv_b = 1'b0;

  always @(negedge clk) begin : rx_mon
    if (rxv_a) begin
      if (rxq_a.size() == 0)
        chk("rx_a_unexp", 64'(rxq_a.size()), 64'd1);
      else
        chk("rx_a_flit", 64'(rxf_a),
            64'(rxq_a.pop_front()));
      if (prev_rxv_a)
        chk("rx_a_pulse", 64'(prev_rxv_a), 64'd0);
    end
    if (rxv_b) begin
      if (rxq_b.size() == 0)
        chk("rx_b_unexp", 64'(rxq_b.size()), 64'd1);
      else
        chk("rx_b_flit", 64'(rxf_b),
            64'(rxq_b.pop_front()));
      if (prev_rxv_b)
        chk("rx_b_pulse", 64'(prev_rxv_b), 64'd0);
    end
    prev_rxv_a <= rxv_a;
    prev_rxv_b <= rxv_b;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic push_a(input logic [63:0] rel_t,
                        input br_tgt_t tg,
                        input br_pl_t pl,
                        input br_svc_t s,
                        input bit exact,
                        input logic [63:0] at_off,
                        output logic [63:0] t_abs);
    int n;
    br_data_t f;
    n = 0;
    @(negedge clk);
    while (!ifa.cmd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    t_abs = tick + rel_t;
    if (!ifa.cmd_ready_o) begin
      chk("push_ready", 64'(ifa.cmd_ready_o), 64'd1);
      return;
    end
    ifa.cmd_valid_i   = 1'b1;
    ifa.cmd_time_i    = t_abs;
    ifa.cmd_target_i  = tg;
    ifa.cmd_payload_i = pl;
    ifa.cmd_service_i = s;
    f.seq_source = 8'd5;
    f.seq_target = tg;
    f.payload    = pl;
    f.service    = s;
    f.id         = 5'(exp_id);
    txq.push_back('{flit: f, at: t_abs + at_off,
                    exact: exact});
    exp_id++;
    @(posedge clk);
    #1 ifa.cmd_valid_i = 1'b0;
  endtask

  function automatic logic ack_of(input bit b);
    return b ? ifb.noc_ack_o : ifa.noc_ack_o;
  endfunction

  task automatic deliver(input bit b,
                         input br_data_t f,
                         input int exp_cyc);
    int n;
    @(negedge clk);
    if (b) begin
      ifb.noc_flit_i = f;
      ifb.noc_req_i  = 1'b1;
      rxq_b.push_back(f);
    end else begin
      ifa.noc_flit_i = f;
      ifa.noc_req_i  = 1'b1;
      rxq_a.push_back(f);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_of(b) && n < 30);
    chk(b ? "rx_b_ack_lat" : "rx_a_ack_lat",
        64'(n), 64'(exp_cyc));
    if (b) ifb.noc_req_i = 1'b0;
    else   ifa.noc_req_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack_of(b) && n < 30);
    chk("rx_ack_fall", 64'(ack_of(b)), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    exp_id = 0;
  endtask

  task automatic wait_idle_a(input int lim);
    int n;
    n = 0;
    while (!(idle_a && txq.size() == 0 &&
             !ifa.noc_ack_i) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("idle_a", 64'(idle_a), 64'd1);
  endtask

  logic [63:0] t0, tx;
  br_data_t    fl;
  int          n;

  initial begin
    rst_n = 1'b0;
    ifa.cmd_valid_i = 0; ifa.cmd_time_i = '0;
    ifa.cmd_target_i = '0; ifa.cmd_payload_i = '0;
    ifa.cmd_service_i = BR_SVC_ALL;
    ifa.noc_busy_i = 0; ifa.noc_flit_i = '0;
    ifa.noc_req_i = 0;
    ifb.cmd_valid_i = 0; ifb.cmd_time_i = '0;
    ifb.cmd_target_i = '0; ifb.cmd_payload_i = '0;
    ifb.cmd_service_i = BR_SVC_ALL;
    ifb.noc_busy_i = 0; ifb.noc_flit_i = '0;
    ifb.noc_req_i = 0; ifb.noc_ack_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ifa.cmd_ready_o), 64'd1);
    chk("rst_idle", 64'(idle_a), 64'd1);
    chk("rst_req", 64'(ifa.noc_req_o), 64'd0);
    chk("rst_ack", 64'(ifa.noc_ack_o), 64'd0);
    chk("rst_flit", 64'(ifa.noc_flit_o), 64'd0);
    chk("rst_txcnt", 64'(tx_a), 64'd0);
    chk("rst_rxv", 64'(rxv_a), 64'd0);
    chk("rst_rxall", 64'(rxall_a), 64'd0);
    chk("rst_idle_b", 64'(idle_b), 64'd1);
    rst_n = 1'b1;

    // 1: single timed injection
    push_a(64'd10, 8'd3, 32'hAB, BR_SVC_ALL,
           1'b1, 64'd0, t0);
    wait_idle_a(200);
    chk("t1_txcnt", 64'(tx_a), 64'd1);
    chk("t1_req", 64'(ifa.noc_req_o), 64'd0);

    // 2: busy gating holds injection past its time
    ifa.noc_busy_i = 1'b1;
    push_a(64'd10, 8'd7, 32'hC0FFEE, BR_SVC_TGT,
           1'b1, 64'd11, t0);
    n = 0;
    while (tick < t0 + 64'd11 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t2_no_req_busy", 64'(ifa.noc_req_o), 64'd0);
    ifa.noc_busy_i = 1'b0;
    wait_idle_a(200);
    chk("t2_txcnt", 64'(tx_a), 64'd2);

    // 3: queue ordering and full
    do_reset();
    push_a(64'd50, 8'd1, 32'h11, BR_SVC_TGT,
           1'b1, 64'd0, t0);
    push_a(64'd5, 8'd2, 32'h22, BR_SVC_ALL,
           1'b0, 64'd0, tx);
    push_a(64'd5, 8'd3, 32'h33, BR_SVC_MON,
           1'b0, 64'd0, tx);
    push_a(64'd5, 8'd4, 32'h44, BR_SVC_CLR,
           1'b0, 64'd0, tx);
    chk("t3_full_ready", 64'(ifa.cmd_ready_o), 64'd0);
    @(negedge clk);
    ifa.cmd_valid_i   = 1'b1;
    ifa.cmd_payload_i = 32'h55;
    @(posedge clk);
    #1 ifa.cmd_valid_i = 1'b0;
    wait_idle_a(400);
    chk("t3_txcnt", 64'(tx_a), 64'd4);

    // 4: id wrap across 33 injections
    do_reset();
    for (int i = 0; i < 33; i++)
      push_a(64'd0, 8'(i), 32'(i * 3), BR_SVC_TGT,
             1'b0, 64'd0, tx);
    wait_idle_a(2000);
    chk("t4_txcnt", 64'(tx_a), 64'd33);

    // 5: deliveries with ack latency 3 and 0
    fl = '{seq_source: 8'd9, seq_target: 8'd5,
           payload: 32'hDEAD, service: BR_SVC_ALL,
           id: 5'd7};
    deliver(1'b0, fl, 4);
    chk("t5_rxall_a", 64'(rxall_a), 64'd1);
    chk("t5_rxtgt_a", 64'(rxtgt_a), 64'd0);
    fl = '{seq_source: 8'd1, seq_target: 8'd2,
           payload: 32'hBEEF, service: BR_SVC_TGT,
           id: 5'd3};
    deliver(1'b1, fl, 2);
    chk("t5_rxtgt_b", 64'(rxtgt_b), 64'd1);
    chk("t5_rxall_b", 64'(rxall_b), 64'd0);

    // 6: reset during TX REQ and RX ACK
    hold = 1'b1;
    push_a(64'd0, 8'd6, 32'h66, BR_SVC_ALL,
           1'b0, 64'd0, tx);
    n = 0;
    while (!ifa.noc_req_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    fl = '{seq_source: 8'd4, seq_target: 8'd5,
           payload: 32'h77, service: BR_SVC_ALL,
           id: 5'd1};
    ifa.noc_flit_i = fl;
    ifa.noc_req_i  = 1'b1;
    rxq_a.push_back(fl);
    n = 0;
    while (!ifa.noc_ack_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_pre_req", 64'(ifa.noc_req_o), 64'd1);
    chk("t6_pre_ack", 64'(ifa.noc_ack_o), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_req", 64'(ifa.noc_req_o), 64'd0);
    chk("t6_ack", 64'(ifa.noc_ack_o), 64'd0);
    chk("t6_txcnt", 64'(tx_a), 64'd0);
    chk("t6_rxall", 64'(rxall_a), 64'd0);
    chk("t6_idle", 64'(idle_a), 64'd1);
    chk("t6_ready", 64'(ifa.cmd_ready_o), 64'd1);
    ifa.noc_req_i = 1'b0;
    rst_n  = 1'b1;
    hold   = 1'b0;
    exp_id = 0;

    // saturation on 4-bit counters
    for (int i = 0; i < 17; i++) begin
      fl = '{seq_source: 8'(i), seq_target: 8'd2,
             payload: 32'(i + 100),
             service: BR_SVC_ALL, id: 5'(i)};
      deliver(1'b1, fl, 2);
    end
    chk("t6_sat_all_b", 64'(rxall_b), 64'd15);
    chk("t6_sat_tgt_b", 64'(rxtgt_b), 64'd0);
    repeat (3) @(negedge clk);
    chk("end_idle_a", 64'(idle_a), 64'd1);
    chk("end_idle_b", 64'(idle_b), 64'd1);
    chk("end_txq", 64'(txq.size()), 64'd0);
    chk("end_rxq_a", 64'(rxq_a.size()), 64'd0);
    chk("end_rxq_b", 64'(rxq_b.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
